// File: rtl/reg_chain_rr_sched_if.sv
// reg_chain_rr_sched_if: requester, output and control bundle of the round-robin register-chain scheduler.
interface reg_chain_rr_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
);
    localparam int ID_W = $clog2(NUM_REQ);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     out_valid;
    logic [WIDTH-1:0]         out_data;
    logic [ID_W-1:0]          out_id;
    logic                     out_ready;
    logic                     flush;
    logic                     busy;
    modport master (
        output req_valid, req_data, out_ready, flush,
        input  req_ready, out_valid, out_data, out_id, busy
    );
    modport slave (
        input  req_valid, req_data, out_ready, flush,
        output req_ready, out_valid, out_data, out_id, busy
    );
endinterface

// File: rtl/reg_chain_rr_sched.sv
// reg_chain_rr_sched: round-robin grant into a shared bubble-collapsing register chain with ID-tagged output.
module reg_chain_rr_sched #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int STAGES  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    reg_chain_rr_sched_if.slave  bus
);
    localparam int ID_W = $clog2(NUM_REQ);
    logic [ID_W-1:0]  r_ptr;
    logic [STAGES-1:0] r_v;
    logic [WIDTH-1:0] r_d  [STAGES];
    logic [ID_W-1:0]  r_id [STAGES];
    logic [STAGES-1:0] w_adv;
    logic [ID_W-1:0]  w_gid;
    logic [ID_W-1:0]  w_idx;
    logic [WIDTH-1:0] w_gdata;
    logic             w_found;
    logic             w_take;
    // A stage may load when it or any stage downstream of it is empty, or the output drains.
    for (genvar s = 0; s < STAGES; s++) begin : g_adv
        assign w_adv[s] = bus.out_ready | ~&r_v[STAGES-1:s];
    end
    // Scan from farthest to nearest so the first valid requester at or after r_ptr wins.
    always_comb begin
        w_found = 1'b0;
        w_gid   = '0;
        w_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = ID_W'((int'(r_ptr) + k) % NUM_REQ);
            if (bus.req_valid[w_idx]) begin
                w_found = 1'b1;
                w_gid   = w_idx;
            end
        end
    end
    always_comb begin
        w_gdata = '0;
        for (int i = 0; i < NUM_REQ; i++)
            w_gdata = (w_gid == ID_W'(i)) ? bus.req_data[i*WIDTH +: WIDTH] : w_gdata;
    end
    assign w_take        = w_found & w_adv[0] & ~bus.flush & rst_n;
    assign bus.req_ready = w_take ? (NUM_REQ'(1) << w_gid) : '0;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v   <= '0;
            r_ptr <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_d[k]  <= '0;
                r_id[k] <= '0;
            end
        end else begin
            if (w_take)
                r_ptr <= ID_W'((int'(w_gid) + 1) % NUM_REQ);
            if (w_adv[0]) begin
                r_v[0]  <= w_take;
                r_d[0]  <= w_gdata;
                r_id[0] <= w_gid;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (w_adv[k]) begin
                    r_v[k]  <= r_v[k-1];
                    r_d[k]  <= r_d[k-1];
                    r_id[k] <= r_id[k-1];
                end
            end
            if (bus.flush)
                r_v <= '0;
        end
    end
    assign bus.out_valid = r_v[STAGES-1];
    assign bus.out_data  = r_d[STAGES-1];
    assign bus.out_id    = r_id[STAGES-1];
    assign bus.busy      = |r_v;
endmodule

// File: tb/tb_reg_chain_rr_sched.sv
// tb_reg_chain_rr_sched: directed checks of latency, fairness, pointer wrap, backpressure, flush and reset.
module tb_reg_chain_rr_sched;
    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_fail;
    int   n_tot;
    reg_chain_rr_sched_if #(.NUM_REQ(4), .WIDTH(8)) bus ();
    reg_chain_rr_sched #(.NUM_REQ(4), .WIDTH(8), .STAGES(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask
    initial begin
        n_pass = 0;
        n_fail = 0;
        n_tot  = 0;
        rst_n         = 1'b0;
        bus.req_valid = 4'hF;
        bus.req_data  = '0;
        bus.out_ready = 1'b1;
        bus.flush     = 1'b0;
        #1;
        chk("rst_rdy", bus.req_ready, 0);
        tick();
        tick();
        rst_n         = 1'b1;
        bus.req_valid = 4'h0;
        #1;
        chk("rst_ov", bus.out_valid, 0);
        chk("rst_dat", bus.out_data, 0);
        chk("rst_id", bus.out_id, 0);
        chk("rst_busy", bus.busy, 0);
        // latency: single word from requester 2
        bus.req_valid = 4'b0100;
        bus.req_data[16 +: 8] = 8'hA5;
        #1;
        chk("lat_rdy", bus.req_ready, 4'b0100);
        tick();
        bus.req_valid = 4'b0000;
        #1;
        chk("lat_busy1", bus.busy, 1);
        chk("lat_ov1", bus.out_valid, 0);
        tick();
        chk("lat_busy2", bus.busy, 1);
        chk("lat_ov2", bus.out_valid, 0);
        tick();
        chk("lat_ov3", bus.out_valid, 1);
        chk("lat_dat", bus.out_data, 8'hA5);
        chk("lat_id", bus.out_id, 2);
        chk("lat_busy3", bus.busy, 1);
        tick();
        chk("lat_ov4", bus.out_valid, 0);
        chk("lat_busy4", bus.busy, 0);
        // fairness: all four requesters valid, pointer from reset
        do_reset();
        for (int i = 0; i < 4; i++) bus.req_data[i*8 +: 8] = 8'h10 + 8'(i);
        bus.req_valid = 4'hF;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("fair_rdy", bus.req_ready, 32'd1 << (c % 4));
            if (c >= 3) begin
                chk("fair_ov", bus.out_valid, 1);
                chk("fair_id", bus.out_id, (c - 3) % 4);
                chk("fair_dat", bus.out_data, 32'h10 + ((c - 3) % 4));
            end else begin
                chk("fair_ov0", bus.out_valid, 0);
            end
            tick();
        end
        bus.req_valid = 4'h0;
        for (int c = 0; c < 4; c++) tick();
        chk("fair_drain", bus.busy, 0);
        // pointer skip and wrap
        bus.req_valid = 4'b0001;
        #1;
        chk("ptr_g0", bus.req_ready, 4'b0001);
        tick();
        bus.req_valid = 4'b0010;
        #1;
        chk("ptr_g1", bus.req_ready, 4'b0010);
        tick();
        bus.req_valid = 4'b0100;
        #1;
        chk("ptr_g2", bus.req_ready, 4'b0100);
        tick();
        bus.req_valid = 4'b0010;
        #1;
        chk("ptr_wrap1", bus.req_ready, 4'b0010);
        tick();
        bus.req_valid = 4'b0001;
        #1;
        chk("ptr_only0", bus.req_ready, 4'b0001);
        tick();
        bus.req_valid = 4'b1001;
        #1;
        chk("ptr_skip3", bus.req_ready, 4'b1000);
        tick();
        bus.req_valid = 4'b0000;
        for (int c = 0; c < 4; c++) tick();
        chk("ptr_drain", bus.busy, 0);
        // backpressure and bubble collapse
        bus.out_ready = 1'b0;
        bus.req_valid = 4'b0001;
        bus.req_data[0 +: 8] = 8'h01;
        #1;
        chk("bp_rdy_a", bus.req_ready, 4'b0001);
        tick();
        bus.req_valid = 4'b0000;
        tick();
        bus.req_valid = 4'b0010;
        bus.req_data[8 +: 8] = 8'h02;
        #1;
        chk("bp_rdy_b", bus.req_ready, 4'b0010);
        tick();
        bus.req_valid = 4'b0000;
        #1;
        chk("bp_ov", bus.out_valid, 1);
        chk("bp_dat1", bus.out_data, 8'h01);
        tick();
        chk("bp_dat2", bus.out_data, 8'h01);
        chk("bp_id2", bus.out_id, 0);
        bus.req_valid = 4'b0100;
        bus.req_data[16 +: 8] = 8'h03;
        #1;
        chk("bp_rdy_c", bus.req_ready, 4'b0100);
        tick();
        bus.req_valid = 4'b1000;
        bus.req_data[24 +: 8] = 8'h04;
        #1;
        chk("bp_full", bus.req_ready, 0);
        chk("bp_dat3", bus.out_data, 8'h01);
        tick();
        chk("bp_full2", bus.req_ready, 0);
        chk("bp_dat4", bus.out_data, 8'h01);
        bus.req_valid = 4'b0000;
        bus.out_ready = 1'b1;
        #1;
        chk("bp_rel_ov", bus.out_valid, 1);
        chk("bp_rel_d1", bus.out_data, 8'h01);
        tick();
        chk("bp_rel_d2", bus.out_data, 8'h02);
        chk("bp_rel_id2", bus.out_id, 1);
        tick();
        chk("bp_rel_d3", bus.out_data, 8'h03);
        chk("bp_rel_id3", bus.out_id, 2);
        tick();
        chk("bp_empty", bus.out_valid, 0);
        // flush with three words in flight, pointer at 3
        bus.req_valid = 4'b1000;
        bus.req_data[24 +: 8] = 8'h31;
        #1;
        chk("fl_rdy3", bus.req_ready, 4'b1000);
        tick();
        bus.req_valid = 4'b0001;
        bus.req_data[0 +: 8] = 8'h32;
        tick();
        bus.req_valid = 4'b0010;
        bus.req_data[8 +: 8] = 8'h33;
        tick();
        bus.flush     = 1'b1;
        bus.req_valid = 4'b0100;
        bus.req_data[16 +: 8] = 8'h44;
        #1;
        chk("fl_rdy", bus.req_ready, 0);
        chk("fl_ov", bus.out_valid, 1);
        chk("fl_dat", bus.out_data, 8'h31);
        chk("fl_id", bus.out_id, 3);
        tick();
        bus.flush = 1'b0;
        #1;
        chk("fl_ov_after", bus.out_valid, 0);
        chk("fl_busy_after", bus.busy, 0);
        chk("fl_rdy_after", bus.req_ready, 4'b0100);
        tick();
        bus.req_valid = 4'b0000;
        tick();
        tick();
        chk("fl_out_ov", bus.out_valid, 1);
        chk("fl_out_dat", bus.out_data, 8'h44);
        chk("fl_out_id", bus.out_id, 2);
        tick();
        chk("fl_idle", bus.busy, 0);
        // reset with a full, stalled chain
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) bus.req_data[i*8 +: 8] = 8'h10 + 8'(i);
        bus.req_valid = 4'hF;
        #1;
        chk("mr_rdy3", bus.req_ready, 4'b1000);
        tick();
        tick();
        tick();
        chk("mr_full", bus.req_ready, 0);
        chk("mr_ov", bus.out_valid, 1);
        chk("mr_dat", bus.out_data, 8'h13);
        chk("mr_id", bus.out_id, 3);
        rst_n = 1'b0;
        #1;
        chk("mr_rst_rdy", bus.req_ready, 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("mr_ov0", bus.out_valid, 0);
        chk("mr_dat0", bus.out_data, 0);
        chk("mr_id0", bus.out_id, 0);
        chk("mr_busy0", bus.busy, 0);
        chk("mr_ptr0", bus.req_ready, 4'b0001);
        tick();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
